debounce_multi: RTL
===================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button channels, 1..32.
REQ-002 Parameter CLK_FREQ, default 12000000: clk frequency in Hz.
REQ-003 Parameter SAMPLE_HZ, default 200: sampling rate; DIV = CLK_FREQ/SAMPLE_HZ (integer, >= 2).
REQ-004 Parameter DEPTH, default 8: consecutive equal samples required to change state, 2..32.
REQ-005 Parameter ACTIVE_LOW, default 0: when 1, raw inputs are inverted before synchronisation.
REQ-006 Parameter LONG_SAMPLES, default 200: samples of continuous press before a long-press event, >= 1.
REQ-007 clk  input  1  single clock; all logic in this domain.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 button  input  CHANNELS  raw asynchronous button lines.
REQ-010 button_db  output  CHANNELS  debounced level per channel (1 = pressed).
REQ-011 button_rising  output  CHANNELS  one-clk pulse on debounced press.
REQ-012 button_falling  output  CHANNELS  one-clk pulse on debounced release.
REQ-013 long_press  output  CHANNELS  one-clk pulse when press held LONG_SAMPLES samples.
REQ-014 sample_tick  output  1  one-clk pulse marking each sample instant.

Function
REQ-015 Each channel SHALL pass its (optionally inverted) input through a two-flop synchroniser.
REQ-016 A shared counter SHALL count 0..DIV-1 and wrap; sample_tick SHALL be 1 exactly in cycles where count == DIV-1.
REQ-017 On each sample_tick, every channel SHALL shift its synchroniser output into a DEPTH-bit shift register (LSB = newest).
REQ-018 button_db SHALL update on the clk edge after the shift register changes: set if all ones, clear if all zeros, otherwise hold (hysteresis).
REQ-019 button_rising/button_falling SHALL assert for exactly one clk, in the cycle after button_db goes 0->1 / 1->0 respectively; never both in the same cycle.
REQ-020 A bounce burst in which the sampled value never stays constant for DEPTH consecutive samples SHALL cause no change on button_db and no pulses.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 Worst-case press latency, input step to button_db = 1: 2 + DEPTH*DIV + 1 clk cycles.

Reset
REQ-023 While rst_n = 0: synchronisers, shift registers, tick counter, long-press counters, and all outputs SHALL be 0, regardless of clk.
REQ-024 Reset deassertion SHALL be synchronised internally (two-flop release); the first sample_tick SHALL occur DIV cycles after the release completes.
REQ-025 Reset asserted mid-press SHALL drop button_db without generating a button_falling pulse.

Configuration
REQ-026 Macro DEBOUNCE_LONG_PRESS_EN, when defined: each channel has a saturating counter cleared while button_db = 0 and incremented on each sample_tick while button_db = 1; long_press pulses one clk when the counter first reaches LONG_SAMPLES, with no repeat until release and re-press.
REQ-027 Without DEBOUNCE_LONG_PRESS_EN: no counters are synthesised; long_press SHALL be tied to 0; all other behaviour is unchanged.

Verification
(bench parameters: CHANNELS=2, CLK_FREQ=1000, SAMPLE_HZ=100 (DIV=10), DEPTH=4, LONG_SAMPLES=8, macro defined unless stated)
REQ-028 Hold rst_n=0, button=2'b11 for 50 cycles -> all outputs 0, sample_tick 0.
REQ-029 Release reset, hold button[0]=1 -> button_db[0]=1 within 43 cycles; button_rising[0] high for exactly 1 cycle; channel 1 unaffected.
REQ-030 Toggle button[0] every 15 cycles for 200 cycles -> button_db[0], button_rising[0], and button_falling[0] stay 0.
REQ-031 Press both channels on the same cycle, hold 120 cycles, release -> identical rising/falling pulse timing on both channels; long_press pulses once per channel, 8 ticks after button_db rises.
REQ-032 ACTIVE_LOW=1, button idle 2'b11, drive button[1]=0 -> button_db[1]=1; assert rst_n=0 mid-press -> button_db=0 immediately, no button_falling pulse.
REQ-033 Rebuild without DEBOUNCE_LONG_PRESS_EN, repeat REQ-031 -> long_press stays 0; all other outputs identical.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: shared sample tick, per-channel DEPTH-sample agreement
// filter, edge pulses, and optional long-press pulses (enabled by DEBOUNCE_LONG_PRESS_EN).
module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int CLK_FREQ     = 12000000,
  parameter int SAMPLE_HZ    = 200,
  parameter int DEPTH        = 8,
  parameter int ACTIVE_LOW   = 0,
  parameter int LONG_SAMPLES = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_db,
  output logic [CHANNELS-1:0] button_rising,
  output logic [CHANNELS-1:0] button_falling,
  output logic [CHANNELS-1:0] long_press,
  output logic                sample_tick
);

  localparam int DIV = CLK_FREQ / SAMPLE_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]          r_rst_sync;
  logic                w_run;
  logic [CHANNELS-1:0] w_in;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CW-1:0]       r_cnt;
  logic                w_tick;
  logic [DEPTH-1:0]    r_shift [CHANNELS];
  logic [CHANNELS-1:0] r_db;
  logic [CHANNELS-1:0] r_db_d;

  assign w_run  = r_rst_sync[1];
  assign w_in   = (ACTIVE_LOW != 0) ? ~button : button;
  assign w_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // Only the first synchroniser stage and the tick counter need gating during release;
  // everything downstream stays at zero because no tick and no non-zero sample can arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_run ? w_in : '0;
      r_sync2 <= r_sync1;
      if (!w_run || w_tick) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) r_shift[ch] <= '0;
      r_db   <= '0;
      r_db_d <= '0;
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if (w_tick) r_shift[ch] <= {r_shift[ch][DEPTH-2:0], r_sync2[ch]};
        if (&r_shift[ch])       r_db[ch] <= 1'b1;
        else if (~|r_shift[ch]) r_db[ch] <= 1'b0;
      end
      r_db_d <= r_db;
    end
  end

  assign button_db      = r_db;
  assign button_rising  = r_db & ~r_db_d;
  assign button_falling = ~r_db & r_db_d;
  assign sample_tick    = w_tick;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_SAMPLES + 1);

  logic [LW-1:0]       r_lcnt [CHANNELS];
  logic [CHANNELS-1:0] r_long;

  // Counter saturates at LONG_SAMPLES so the pulse fires once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) r_lcnt[ch] <= '0;
      r_long <= '0;
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        r_long[ch] <= 1'b0;
        if (!r_db[ch]) begin
          r_lcnt[ch] <= '0;
        end else if (w_tick && (r_lcnt[ch] != LW'(LONG_SAMPLES))) begin
          r_lcnt[ch] <= r_lcnt[ch] + 1'b1;
          if (r_lcnt[ch] == LW'(LONG_SAMPLES - 1)) r_long[ch] <= 1'b1;
        end
      end
    end
  end

  assign long_press = r_long;
`else
  assign long_press = '0;
`endif

endmodule
